// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule generator.
// Loads the 16 words of one 512-bit block serially, then emits W[0..ROUNDS-1]
// one word per output handshake, expanding W[16+] on the fly in a 16-word
// shift window whose head w[0] is always the word being offered.
//
// Handshakes: a word moves on a port exactly in the cycle where that port's
// valid and ready are both high at the rising clock edge. in_ready and
// out_valid depend only on registered state, never on the opposite
// handshake input, so there is no combinational path through the block.
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_index,
  output logic        out_last,
  output logic        busy,
  output logic        dbg_state
);

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [5:0]  t_q;
  logic [31:0] w_q [16];
  logic [31:0] w15_d;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Next window tail: W[t+16] from the current window, carries past bit 31 dropped.
  always_comb begin
    w15_d = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
  end

  // Load/emit control, load counter, round index and the shift window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= 4'd0;
      t_q     <= 6'd0;
      for (int i = 0; i < 16; i++) w_q[i] <= 32'd0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            w_q[cnt_q] <= in_data;
            if (cnt_q == 4'd15) begin
              state_q <= EMIT;
              cnt_q   <= 4'd0;
              t_q     <= 6'd0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
            w_q[15] <= w15_d;
            if (t_q == LAST_T) begin
              state_q <= LOAD;
              t_q     <= 6'd0;
            end else begin
              t_q <= t_q + 6'd1;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // Outputs decoded purely from registers.
  always_comb begin
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == EMIT);
    out_word  = w_q[0];
    out_index = t_q;
    out_last  = (state_q == EMIT) && (t_q == LAST_T);
    busy      = (state_q == EMIT) || (cnt_q != 4'd0);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: software SHA-256 schedule
// model, expected-word queue, per-cycle compare process, plus a ROUNDS=16 build.
module tb_sha256_msg_schedule;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] sched_t [64];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (ROUNDS=64) ----------------
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] in_data = 32'd0, out_word;
  logic [5:0]  out_index;
  logic        out_last, busy, dbg_state;

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_index(out_index), .out_last(out_last), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- DUT (ROUNDS=16) ----------------
  logic        in_valid16 = 1'b0, in_ready16, out_valid16;
  logic        out_ready16 = 1'b1;
  logic [31:0] in_data16 = 32'd0, out_word16;
  logic [5:0]  out_index16;
  logic        out_last16, busy16, dbg_state16;

  sha256_msg_schedule #(.ROUNDS(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_word(out_word16),
    .out_index(out_index16), .out_last(out_last16), .busy(busy16), .dbg_state(dbg_state16)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [38:0] exp_q[$];           // {last, index, word}
  logic [31:0] got [64];
  bit          mon_on = 1'b0;
  bit          bp_mode = 1'b0;
  bit          prev_last_xfer = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic sched_t schedule(input blk_t b);
    sched_t w;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = b[t];
      else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    return w;
  endfunction

  task automatic push_expected(input blk_t b, input int rounds);
    sched_t w;
    w = schedule(b);
    for (int t = 0; t < rounds; t++)
      exp_q.push_back({(t == rounds - 1), 6'(t), w[t]});
  endtask

  // ---------------- out_ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst && mon_on) begin
      check("in_ready_vs_out_valid", {63'd0, in_ready}, {63'd0, !out_valid});
      if (prev_last_xfer) begin
        check("ready_after_last", {62'd0, in_ready, out_valid}, 64'b10);
      end
      if (out_valid) begin
        check("busy_in_emit", {63'd0, busy}, 64'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_word", {32'd0, out_word}, 64'hDEAD_0000_0000_0000);
        end else begin
          check("out_word", {32'd0, out_word}, {32'd0, exp_q[0][31:0]});
          check("out_index_last", {57'd0, out_last, out_index}, {57'd0, exp_q[0][38:32]});
          if (out_ready) begin
            got[out_index] = out_word;
            void'(exp_q.pop_front());
          end
        end
      end
      prev_last_xfer = out_valid && out_ready && out_last;
    end else begin
      prev_last_xfer = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Loads one block; random idle gaps when gaps=1; leaves in_valid high when hold=1.
  task automatic load_block(input blk_t b, input bit gaps, input bit hold, input bit check_lat);
    int guard;
    for (int i = 0; i < 16; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b[i];
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 500) check("in_ready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;     // transfer happens at this edge
    end
    if (!hold) in_valid = 1'b0;
    if (check_lat) begin
      @(negedge clk);
      check("latency_out_valid", {63'd0, out_valid}, 64'd1);
      check("latency_out_index", {58'd0, out_index}, 64'd0);
      check("latency_in_ready", {63'd0, in_ready}, 64'd0);
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 3000) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    blk_t   abc, ones, rnd;
    sched_t m;
    int     guard;

    abc = '{default: 32'd0};
    abc[0]  = 32'h6162_6380;
    abc[15] = 32'h0000_0018;
    ones = '{default: 32'hFFFF_FFFF};

    // model pins
    m = schedule(abc);
    check("model_w16", {32'd0, m[16]}, 64'h6162_6380);
    check("model_w17", {32'd0, m[17]}, 64'h000F_0000);
    check("model_w63", {32'd0, m[63]}, 64'h12B1_EDEB);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_flags", {59'd0, out_valid, out_last, busy, in_ready16, out_valid16}, 64'b00010);
    check("rst_out_word_idx", {26'd0, out_index, out_word}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1'b1;

    // test 1/2: abc block, unstalled, latency
    push_expected(abc, 64);
    load_block(abc, 1'b0, 1'b0, 1'b1);
    wait_drain();
    check("abc_w16", {32'd0, got[16]}, 64'h6162_6380);
    check("abc_w17", {32'd0, got[17]}, 64'h000F_0000);
    check("abc_w63", {32'd0, got[63]}, 64'h12B1_EDEB);
    check("idle_after_block", {62'd0, in_ready, busy}, 64'b10);

    // test 3: backpressure, idle gaps on the input
    bp_mode = 1'b1;
    got = '{default: 32'd0};
    push_expected(abc, 64);
    load_block(abc, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check("bp_w63", {32'd0, got[63]}, 64'h12B1_EDEB);

    // test 4: back-to-back blocks, in_valid held high
    bp_mode = 1'b0;
    push_expected(abc, 64);
    push_expected(ones, 64);
    load_block(abc, 1'b0, 1'b1, 1'b0);
    load_block(ones, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // random blocks with random backpressure
    bp_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) rnd[i] = $urandom;
      push_expected(rnd, 64);
      load_block(rnd, 1'b1, 1'b0, 1'b0);
      wait_drain();
    end

    // test 5: reset mid-emit around t=30
    bp_mode = 1'b0;
    push_expected(abc, 64);
    load_block(abc, 1'b0, 1'b0, 1'b0);
    guard = 0;
    @(negedge clk);
    while (!(out_valid && out_index == 6'd30) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("t30_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_flags", {61'd0, out_valid, in_ready, busy}, 64'b010);
    check("midrst_index", {58'd0, out_index}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    got = '{default: 32'd0};
    push_expected(abc, 64);
    load_block(abc, 1'b0, 1'b0, 1'b1);
    wait_drain();
    check("post_rst_w63", {32'd0, got[63]}, 64'h12B1_EDEB);

    // test 6: ROUNDS=16 build
    m = schedule(abc);
    for (int i = 0; i < 16; i++) begin
      in_valid16 = 1'b1;
      in_data16  = abc[i];
      @(posedge clk); #1;
    end
    in_valid16 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("r16_valid", {63'd0, out_valid16}, 64'd1);
      check("r16_word", {32'd0, out_word16}, {32'd0, m[k]});
      check("r16_idx_last", {57'd0, out_last16, out_index16}, {57'd0, (k == 15), 6'(k)});
    end
    @(negedge clk);
    check("r16_back_to_load", {61'd0, in_ready16, out_valid16, busy16}, 64'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
